// File: rtl/mem_arbiter_pkg.sv
// Memory-port types (wires) and the arbiter's state and pending-latch types (arbiter_wires).
package wires;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_spec;
        logic        mem_instr;
        logic [1:0]  mem_mode;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_error;
        logic        mem_ready;
    } mem_out_type;

endpackage

package arbiter_wires;

    import wires::*;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        valid;
        logic        spec;
        logic        fence;
        logic        instr;
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } pend_t;

    // Shared by both latches; the fetch side forces instr so memory can tell the paths apart.
    function automatic pend_t load_pend(input mem_in_type req, input logic force_instr);
        pend_t p;
        p.valid = req.mem_valid;
        p.spec  = req.mem_spec;
        p.fence = req.mem_fence;
        p.instr = req.mem_instr | force_instr;
        p.mode  = req.mem_mode;
        p.addr  = req.mem_addr;
        p.wdata = req.mem_wdata;
        p.wstrb = req.mem_wstrb;
        return p;
    endfunction

    function automatic mem_in_type issue_req(input pend_t p);
        mem_in_type r;
        r.mem_valid = p.valid;
        r.mem_fence = p.fence;
        r.mem_spec  = p.spec;
        r.mem_instr = p.instr;
        r.mem_mode  = p.mode;
        r.mem_addr  = p.addr;
        r.mem_wdata = p.wdata;
        r.mem_wstrb = p.wstrb;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data paths, one transaction outstanding.
// Define ARBITER_FAIRNESS_EN to cap consecutive data grants while a fetch waits.
module mem_arbiter
    import wires::*;
    import arbiter_wires::*;
#(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output mem_in_type  mem_in,
    input  mem_out_type mem_out
);

    if (MAX_DATA_BURST < 1 || MAX_DATA_BURST > 15) begin : g_bad_burst
        $error("MAX_DATA_BURST must be in 1..15");
    end

    arb_state_t state;
    pend_t      ipend;
    pend_t      dpend;
    pend_t      ipend_next;
    pend_t      dpend_next;
    logic       squash;
    logic       complete;
    logic       redirect;
    logic       can_arb;
    logic       grant_i;
    logic       grant_d;

`ifdef ARBITER_FAIRNESS_EN
    logic [3:0] burst_cnt;
    logic       burst_hit;
`endif

    always_comb begin
        complete   = (state != IDLE) && mem_out.mem_ready;
        redirect   = (state == BUSY_I) && (imem_in.mem_spec || imem_in.mem_fence);
        can_arb    = (state == IDLE) || complete;

        // A redirect may reload the fetch latch even while the old fetch is in flight.
        ipend_next = ipend;
        if (imem_in.mem_valid && ((state != BUSY_I) || redirect))
            ipend_next = load_pend(imem_in, 1'b1);

        dpend_next = dpend;
        if (dmem_in.mem_valid && !dpend.valid && ((state != BUSY_D) || complete))
            dpend_next = load_pend(dmem_in, 1'b0);

`ifdef ARBITER_FAIRNESS_EN
        burst_hit = (burst_cnt == 4'(MAX_DATA_BURST));
        grant_i   = can_arb && ipend_next.valid && (!dpend_next.valid || burst_hit);
`else
        grant_i   = can_arb && ipend_next.valid && !dpend_next.valid;
`endif
        grant_d    = can_arb && dpend_next.valid && !grant_i;
    end

    // Responses are combinational so the owner sees them in the memory's ready cycle.
    always_comb begin
        imem_out = '0;
        dmem_out = '0;
        if (complete && (state == BUSY_D)) begin
            dmem_out.mem_rdata = mem_out.mem_rdata;
            dmem_out.mem_error = mem_out.mem_error;
            dmem_out.mem_ready = 1'b1;
        end
        if (complete && (state == BUSY_I) && !(squash || redirect)) begin
            imem_out.mem_rdata = mem_out.mem_rdata;
            imem_out.mem_error = mem_out.mem_error;
            imem_out.mem_ready = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ipend  <= '0;
            dpend  <= '0;
            squash <= 1'b0;
            mem_in <= '0;
`ifdef ARBITER_FAIRNESS_EN
            burst_cnt <= '0;
`endif
        end else begin
            mem_in <= '0;
            ipend  <= ipend_next;
            dpend  <= dpend_next;
            squash <= complete ? 1'b0 : (squash || redirect);

            if (grant_i) begin
                mem_in <= issue_req(ipend_next);
                ipend  <= '0;
                state  <= BUSY_I;
            end else if (grant_d) begin
                mem_in <= issue_req(dpend_next);
                dpend  <= '0;
                state  <= BUSY_D;
            end else if (can_arb) begin
                state  <= IDLE;
            end

`ifdef ARBITER_FAIRNESS_EN
            if (grant_i)
                burst_cnt <= '0;
            else if (grant_d && ipend_next.valid)
                burst_cnt <= burst_cnt + 4'd1;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction model predicts issues and responses, monitor compares.
module tb_mem_arbiter;

    import wires::*;

    localparam int MAX_BURST = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    mem_in_type  imem_in;
    mem_in_type  dmem_in;
    mem_in_type  mem_in;
    mem_out_type imem_out;
    mem_out_type dmem_out;
    mem_out_type mem_out;

    mem_arbiter #(.MAX_DATA_BURST(MAX_BURST)) dut (
        .clock    (clock),
        .reset    (reset),
        .imem_in  (imem_in),
        .imem_out (imem_out),
        .dmem_in  (dmem_in),
        .dmem_out (dmem_out),
        .mem_in   (mem_in),
        .mem_out  (mem_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic        instr;
        logic        spec;
        logic        fence;
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } issue_t;

    typedef struct {
        int          cyc;
        logic        to_i;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    bit     monitor_on = 0;
    issue_t exp_issue[$];
    resp_t  exp_resp[$];

    // Transaction-level model: who owns the port, what is waiting, when memory answers.
    int     m_state;      // 0 idle, 1 fetch in flight, 2 data in flight
    bit     m_squash;
    bit     i_has;
    issue_t i_req;
    issue_t d_q[$];
    int     ready_cyc;
    int     burst;
    int     next_lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic report(input string name, input logic [63:0] val);
        n_checks++;
        n_fail++;
        $display("FAIL %s: value %0h (cycle %0d)", name, val, cyc);
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_squash = 0;
        i_has    = 0;
        d_q.delete();
        ready_cyc = 0;
        burst    = 0;
        next_lat = 0;
        exp_issue.delete();
        exp_resp.delete();
    endtask

    function automatic bit d_can_pulse();
        return (d_q.size() == 0) && ((m_state != 2) || (ready_cyc == cyc + 1));
    endfunction

    task automatic check_resp(input logic to_i, input mem_out_type o);
        resp_t r;
        if (exp_resp.size() == 0) begin
            report(to_i ? "unexpected_imem_resp" : "unexpected_dmem_resp", 64'(o.mem_rdata));
        end else begin
            r = exp_resp.pop_front();
            check("resp_owner", 64'(to_i), 64'(r.to_i));
            check("resp_cycle", 64'(cyc), 64'(r.cyc));
            check("resp_rdata", 64'(o.mem_rdata), 64'(r.rdata));
            check("resp_error", 64'(o.mem_error), 64'(r.err));
        end
    endtask

    initial begin : monitor
        issue_t e;
        resp_t  r;
        forever begin
            @(negedge clock);
            if (monitor_on) begin
                while (exp_issue.size() > 0 && exp_issue[0].cyc < cyc) begin
                    e = exp_issue.pop_front();
                    report("missed_issue", 64'(e.addr));
                end
                while (exp_resp.size() > 0 && exp_resp[0].cyc < cyc) begin
                    r = exp_resp.pop_front();
                    report("missed_resp", 64'(r.rdata));
                end
                if (mem_in.mem_valid) begin
                    if (exp_issue.size() == 0) begin
                        report("unexpected_issue", 64'(mem_in.mem_addr));
                    end else begin
                        e = exp_issue.pop_front();
                        check("issue_cycle", 64'(cyc), 64'(e.cyc));
                        check("issue_addr", 64'(mem_in.mem_addr), 64'(e.addr));
                        check("issue_instr", 64'(mem_in.mem_instr), 64'(e.instr));
                        check("issue_spec_fence", 64'({mem_in.mem_spec, mem_in.mem_fence}), 64'({e.spec, e.fence}));
                        check("issue_mode", 64'(mem_in.mem_mode), 64'(e.mode));
                        check("issue_wdata", 64'(mem_in.mem_wdata), 64'(e.wdata));
                        check("issue_wstrb", 64'(mem_in.mem_wstrb), 64'(e.wstrb));
                    end
                end
                if (imem_out.mem_ready) check_resp(1'b1, imem_out);
                if (dmem_out.mem_ready) check_resp(1'b0, dmem_out);
            end
        end
    end

    // One clock of stimulus; the model predicts what this cycle's edge will issue and return.
    task automatic step(input bit iv, input bit ispec, input bit ifence, input logic [31:0] iaddr,
                        input bit dv, input logic [31:0] daddr, input logic [31:0] dwdata,
                        input logic [3:0] dwstrb, input bit stale);
        bit          rdy;
        bit          complete;
        bit          redirect;
        bit          pick_i;
        bit          pick_d;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  imode;
        logic [1:0]  dmode;
        logic        dfence;
        issue_t      req;
        resp_t       rsp;

        @(posedge clock);
        #1;
        cyc++;
        rdata  = $urandom;
        err    = ($urandom_range(0, 7) == 0);
        imode  = 2'($urandom_range(0, 3));
        dmode  = 2'($urandom_range(0, 3));
        dfence = dv && ($urandom_range(0, 15) == 0);
        rdy    = (m_state != 0) ? (cyc == ready_cyc) : stale;

        mem_out.mem_ready = rdy;
        mem_out.mem_rdata = rdata;
        mem_out.mem_error = err;

        imem_in.mem_valid = iv;
        imem_in.mem_spec  = ispec;
        imem_in.mem_fence = ifence;
        imem_in.mem_instr = 1'b0;
        imem_in.mem_mode  = imode;
        imem_in.mem_addr  = iaddr;
        imem_in.mem_wdata = '0;
        imem_in.mem_wstrb = '0;

        dmem_in.mem_valid = dv;
        dmem_in.mem_spec  = 1'b0;
        dmem_in.mem_fence = dfence;
        dmem_in.mem_instr = 1'b0;
        dmem_in.mem_mode  = dmode;
        dmem_in.mem_addr  = daddr;
        dmem_in.mem_wdata = dwdata;
        dmem_in.mem_wstrb = dwstrb;

        complete = (m_state != 0) && rdy;
        redirect = (m_state == 1) && (ispec || ifence);

        if (complete) begin
            if (m_state == 2 || !(m_squash || redirect)) begin
                rsp.cyc   = cyc;
                rsp.to_i  = (m_state == 1);
                rsp.rdata = rdata;
                rsp.err   = err;
                exp_resp.push_back(rsp);
            end
            m_squash = 0;
        end else if (redirect) begin
            m_squash = 1;
        end

        if (iv && (m_state != 1 || redirect)) begin
            i_has       = 1;
            i_req.cyc   = 0;
            i_req.instr = 1'b1;
            i_req.spec  = ispec;
            i_req.fence = ifence;
            i_req.mode  = imode;
            i_req.addr  = iaddr;
            i_req.wdata = '0;
            i_req.wstrb = '0;
        end
        if (dv) begin
            req.cyc   = 0;
            req.instr = 1'b0;
            req.spec  = 1'b0;
            req.fence = dfence;
            req.mode  = dmode;
            req.addr  = daddr;
            req.wdata = dwdata;
            req.wstrb = dwstrb;
            d_q.push_back(req);
        end

        if (m_state == 0 || complete) begin
`ifdef ARBITER_FAIRNESS_EN
            pick_i = i_has && (d_q.size() == 0 || burst == MAX_BURST);
`else
            pick_i = i_has && (d_q.size() == 0);
`endif
            pick_d = !pick_i && (d_q.size() > 0);
            if (pick_i) begin
                req     = i_req;
                i_has   = 0;
                burst   = 0;
                m_state = 1;
            end else if (pick_d) begin
                req = d_q.pop_front();
                if (i_has) burst++;
                m_state = 2;
            end else begin
                m_state = 0;
            end
            if (pick_i || pick_d) begin
                req.cyc = cyc + 1;
                exp_issue.push_back(req);
                ready_cyc = cyc + 1 + ((next_lat > 0) ? next_lat : int'($urandom_range(1, 3)));
                next_lat  = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, '0, 0, '0, '0, '0, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin : stimulus
        bit          iv;
        bit          sp;
        bit          fe;
        bit          dv;

        imem_in = '0;
        dmem_in = '0;
        mem_out = '0;
        model_reset();

        // Reset state, with a stray memory ready that must be ignored
        repeat (3) @(posedge clock);
        #1 mem_out.mem_ready = 1'b1;
        #1;
        check("reset_mem_valid", 64'(mem_in.mem_valid), 64'd0);
        check("reset_mem_in_zero", 64'(mem_in != '0), 64'd0);
        check("reset_imem_out_zero", 64'(imem_out != '0), 64'd0);
        check("reset_dmem_out_zero", 64'(dmem_out != '0), 64'd0);
        mem_out = '0;
        @(posedge clock);
        #2 reset = 1'b1;
        monitor_on = 1;

        // Fetch only, latency 3
        next_lat = 3;
        step(1, 0, 0, 32'h100, 0, '0, '0, '0, 0);
        idle(6);

        // Simultaneous data load and fetch: data first
        step(1, 0, 0, 32'h104, 1, 32'h2000, '0, 4'h0, 0);
        idle(10);

        // Redirect during fetch in flight
        next_lat = 3;
        step(1, 0, 0, 32'h200, 0, '0, '0, '0, 0);
        idle(1);
        step(1, 1, 0, 32'h400, 0, '0, '0, '0, 0);
        idle(8);

        // Store passes wdata/wstrb unchanged
        step(0, 0, 0, '0, 1, 32'h3000, 32'hDEADBEEF, 4'hF, 0);
        idle(6);

        // Continuous data with a fetch waiting
        step(1, 0, 0, 32'h500, 1, 32'h6000, $urandom, 4'h0, 0);
        for (int k = 0; k < 40; k++)
            step(0, 0, 0, '0, d_can_pulse(), 32'h6004 + 32'(k * 4), $urandom, 4'($urandom_range(0, 15)), 0);
        idle(10);

        // Randomised traffic, including stray readies while idle
        for (int k = 0; k < 1500; k++) begin
            iv = ($urandom_range(0, 1) == 1);
            sp = iv && ($urandom_range(0, 7) == 0);
            fe = iv && ($urandom_range(0, 15) == 0);
            dv = d_can_pulse() && ($urandom_range(0, 2) == 0);
            step(iv, sp, fe, $urandom & 32'hFFFF_FFFC, dv, $urandom & 32'hFFFF_FFFC, $urandom,
                 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
        end
        idle(10);

        // Reset asserted mid data access
        next_lat = 5;
        step(0, 0, 0, '0, 1, 32'h7000, '0, 4'h0, 0);
        idle(2);
        #3 reset = 1'b0;
        monitor_on = 0;
        #1;
        check("async_reset_mem_in", 64'(mem_in != '0), 64'd0);
        check("async_reset_dmem_ready", 64'(dmem_out.mem_ready), 64'd0);
        @(posedge clock);
        #1 mem_out.mem_ready = 1'b1;
        mem_out.mem_rdata = 32'hCAFE_0001;
        #1;
        check("in_reset_dmem_out", 64'(dmem_out != '0), 64'd0);
        check("in_reset_imem_out", 64'(imem_out != '0), 64'd0);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("post_reset_stale_dmem_ready", 64'(dmem_out.mem_ready), 64'd0);
        check("post_reset_stale_imem_ready", 64'(imem_out.mem_ready), 64'd0);
        @(posedge clock);
        #1 mem_out = '0;
        #1;
        check("post_reset_no_issue", 64'(mem_in.mem_valid), 64'd0);
        model_reset();
        monitor_on = 1;

        // Normal operation resumes
        step(1, 0, 0, 32'h800, 0, '0, '0, '0, 0);
        idle(6);

        check("issues_drained", 64'(exp_issue.size()), 64'd0);
        check("responses_drained", 64'(exp_resp.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one memory port between the instruction-fetch path (the fetch buffer's imem interface) and the data path (load/store unit dmem interface). It keeps at most one transaction outstanding, arbitrates with data priority plus an optional anti-starvation rule, and routes each response back to its owner. It squashes instruction responses made stale by a speculative redirect or fence. It sits between the fetch buffer/LSU and the memory/bus adapter.

## Interface
- MAX_DATA_BURST, 4: consecutive data grants allowed while an instruction request waits (fairness build only); range 1..15.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- imem_in  input  mem_in_type  fetch request: valid, spec, fence, mode, addr.
- imem_out  output  mem_out_type  fetch response: rdata, error, ready.
- dmem_in  input  mem_in_type  data request, including wdata, wstrb and fence.
- dmem_out  output  mem_out_type  data response.
- mem_in  output  mem_in_type  request to memory.
- mem_out  input  mem_out_type  response from memory.

## Operation
- States:
  - IDLE: nothing in flight.
  - BUSY_I: instruction access in flight.
  - BUSY_D: data access in flight.
- Instruction pending latch:
  - Loaded every cycle that imem_in.mem_valid=1 and no instruction access is in flight; the latest address wins.
  - mem_instr is forced to 1.
- Data pending latch:
  - Loaded on a dmem_in.mem_valid=1 pulse.
  - The requester must not pulse again before dmem_out.mem_ready. A pulse while data is already pending or in flight is dropped; the bench asserts this never happens.
- Arbitration runs in IDLE, or in a BUSY state during the cycle mem_out.mem_ready=1:
  - Data pending wins over instruction pending, except under the fairness rule (see Configuration).
- Issue:
  - The granted latch is copied into registered mem_in, with mem_valid=1 for exactly one cycle.
  - The latch is cleared and the state moves to BUSY_I or BUSY_D.
- Completion:
  - mem_out.mem_ready in BUSY_D drives dmem_out as {rdata, error, ready=1} in the same cycle.
  - In BUSY_I it drives imem_out the same way, unless the squash flag is set.
  - With nothing new to grant, the state returns to IDLE.
- Squash:
  - imem_in.mem_spec=1 or imem_in.mem_fence=1 during BUSY_I sets the squash flag.
  - The in-flight response is then consumed but not forwarded (imem_out.mem_ready stays 0).
  - The flag clears on that response.
  - The instruction latch reloads from the redirected address in the same cycle.
- Spec/fence in IDLE or BUSY_D: only the instruction latch is updated; nothing is squashed.
- mem_out.mem_ready in IDLE is ignored; this covers stale responses after reset.

## Timing
- Reset values:
  - Every mem_in, imem_out and dmem_out field is 0.
  - State is IDLE; both latches, squash and the burst counter are 0.
- Request latency: request sampled at edge N, mem_in.mem_valid=1 during cycle N+1.
- Response latency: 0 cycles, purely combinational from mem_out to the owner's out port.
- Back-to-back: the next mem_valid is asserted in the cycle after mem_ready; there are no idle bubbles.
- Simultaneous request arrival in IDLE: data is issued first and instruction next, so the instruction waits for one full data transaction.
- mem_valid is never asserted while a transaction is in flight.

## Configuration
- ARBITER_FAIRNESS_EN defined:
  - A 4-bit counter increments on each data grant made while instruction is pending.
  - When the counter equals MAX_DATA_BURST, instruction wins the next arbitration and the counter clears.
  - The counter also clears on any instruction grant.
- ARBITER_FAIRNESS_EN undefined: strict data priority; the counter is not instantiated.

## Structure
- Shared package arbiter_wires:
  - State enum {IDLE, BUSY_I, BUSY_D}.
  - Pending-request struct {valid, spec, fence, instr, mode, addr, wdata, wstrb}.
- mem_in_type and mem_out_type come from wires.
- Single module with no sub-module. The two pending latches use the same struct and update function.

## Test plan
- Fetch only: imem addr 0x100 with memory latency 3 → mem_in.mem_valid one cycle with addr 0x100 and mem_instr=1; imem_out.mem_ready in the same cycle as mem_out.mem_ready, rdata passed through.
- Same-cycle requests, dmem load 0x2000 and imem 0x104 → mem_in issues 0x2000 first; 0x104 issues in the cycle after the data ready; each response reaches only its owner.
- Redirect: imem_in.mem_spec with addr 0x400 during BUSY_I → the old response is dropped (imem_out.mem_ready=0); next issue is addr 0x400.
- Fairness (ARBITER_FAIRNESS_EN, MAX_DATA_BURST=4): dmem requests continuously with imem pending → exactly 4 data grants, then 1 instruction grant; without the macro, no instruction grant while data keeps arriving.
- Reset low mid BUSY_D, then mem_out.mem_ready pulses → all outputs 0 and dmem_out.mem_ready stays 0.
- Store 0x3000, wstrb=0xF, wdata=0xDEADBEEF → mem_in carries wstrb and wdata unchanged; dmem_out.mem_ready on completion.
